// File: rtl/snap_pkg.sv
// Shared types and width helpers for the cycle snapshot unit.
package snap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD
  } snap_state_e;

  localparam logic KIND_RF = 1'b0;
  localparam logic KIND_DM = 1'b1;

  function automatic int idx_w(input int num_regs, input int num_mem);
    int m;
    m = (num_regs > num_mem) ? num_regs : num_mem;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic int trig_w(input int num_trig);
    return (num_trig <= 1) ? 1 : $clog2(num_trig);
  endfunction

endpackage

// File: rtl/snap_trigger_bank.sv
// Cycle counter, per-slot trigger comparators, pending/fired tracking and
// lowest-index-first selection of the next slot to dump.
module snap_trigger_bank
  import snap_pkg::*;
#(
  parameter int NUM_TRIG = 2,
  parameter int CNT_W    = 16,
  parameter int TRIG_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      freeze,
  input  logic [NUM_TRIG*CNT_W-1:0] trig_cycle,
  input  logic                      take,
  output logic [CNT_W-1:0]          cycle,
  output logic                      any_pending,
  output logic [TRIG_W-1:0]         sel_trig,
  output logic                      all_fired
);

  logic [NUM_TRIG-1:0] pending;
  logic [NUM_TRIG-1:0] fired;
  logic [NUM_TRIG-1:0] match;
  logic [NUM_TRIG-1:0] lowest;
  logic                cnt_en;

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < NUM_TRIG; k++) begin
      if (trig_cycle[k*CNT_W +: CNT_W] == cycle && run && !freeze && !fired[k]) begin
        match[k] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_trig = '0;
    for (int unsigned k = NUM_TRIG; k > 0; k--) begin
      if (pending[k-1]) begin
        sel_trig = TRIG_W'(k - 1);
      end
    end
  end

  // Isolates the lowest set pending bit, i.e. the slot that sel_trig names.
  assign lowest      = pending & (~pending + NUM_TRIG'(1));
  assign any_pending = |pending;
  assign all_fired   = &fired;

  // Holding the count on a match keeps cycle at the trigger value for the
  // whole dump, because freeze only rises on the following cycle.
  assign cnt_en = run && !freeze && !(|match) && (cycle != '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle   <= '0;
      pending <= '0;
      fired   <= '0;
    end else begin
      if (cnt_en) begin
        cycle <= cycle + CNT_W'(1);
      end
      pending <= (pending & ~(take ? lowest : '0)) | match;
      fired   <= fired | match;
    end
  end

endmodule

// File: rtl/cycle_snapshot_unit.sv
// Freezes the CPU at programmed cycles and streams out RF then DM contents.
// Optional macro SNAP_HALT_EN: sticky halt/freeze after the final slot's dump.
module cycle_snapshot_unit
  import snap_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  parameter  int NUM_MEM  = 16,
  parameter  int NUM_TRIG = 2,
  parameter  int CNT_W    = 16,
  localparam int IDX_W    = idx_w(NUM_REGS, NUM_MEM),
  localparam int TRIG_W   = trig_w(NUM_TRIG)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      run_i,
  input  logic [NUM_TRIG*CNT_W-1:0] trig_cycle_i,
  output logic                      freeze_o,
  output logic                      rd_en_o,
  output logic                      rd_kind_o,
  output logic [IDX_W-1:0]          rd_idx_o,
  input  logic [DATA_W-1:0]         rd_data_i,
  output logic                      dump_valid_o,
  input  logic                      dump_ready_i,
  output logic [DATA_W-1:0]         dump_data_o,
  output logic                      dump_kind_o,
  output logic [IDX_W-1:0]          dump_idx_o,
  output logic [TRIG_W-1:0]         dump_trig_o,
  output logic                      dump_last_o,
  output logic [CNT_W-1:0]          cycle_o,
  output logic                      halt_o
);

  localparam logic [IDX_W-1:0] IDX_LAST_RF = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DM = IDX_W'(NUM_MEM - 1);

  snap_state_e         state;
  snap_state_e         state_next;
  logic                kind_q;
  logic [IDX_W-1:0]    idx_q;
  logic [TRIG_W-1:0]   trig_q;
  logic [DATA_W-1:0]   data_q;
  logic                take;
  logic                any_pending;
  logic [TRIG_W-1:0]   sel_trig;
  logic                all_fired;
  logic                halt_q;
  logic                rf_end;
  logic                last_word;

  snap_trigger_bank #(
    .NUM_TRIG (NUM_TRIG),
    .CNT_W    (CNT_W),
    .TRIG_W   (TRIG_W)
  ) u_trigger_bank (
    .clk         (clk_i),
    .rst         (rst_i),
    .run         (run_i),
    .freeze      (freeze_o),
    .trig_cycle  (trig_cycle_i),
    .take        (take),
    .cycle       (cycle_o),
    .any_pending (any_pending),
    .sel_trig    (sel_trig),
    .all_fired   (all_fired)
  );

  assign rf_end    = (kind_q == KIND_RF) && (idx_q == IDX_LAST_RF);
  assign last_word = (kind_q == KIND_DM) && (idx_q == IDX_LAST_DM);
  assign freeze_o  = any_pending || (state != IDLE) || halt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_pending) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (dump_ready_i) state_next = last_word ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    take         = 1'b0;
    rd_en_o      = 1'b0;
    rd_kind_o    = 1'b0;
    rd_idx_o     = '0;
    dump_valid_o = 1'b0;
    dump_data_o  = '0;
    dump_kind_o  = 1'b0;
    dump_idx_o   = '0;
    dump_trig_o  = '0;
    dump_last_o  = 1'b0;
    case (state)
      IDLE: take = any_pending;
      ISSUE: begin
        rd_en_o   = 1'b1;
        rd_kind_o = kind_q;
        rd_idx_o  = idx_q;
      end
      HOLD: begin
        dump_valid_o = 1'b1;
        dump_data_o  = data_q;
        dump_kind_o  = kind_q;
        dump_idx_o   = idx_q;
        dump_trig_o  = trig_q;
        dump_last_o  = last_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kind_q <= KIND_RF;
      idx_q  <= '0;
      trig_q <= '0;
      data_q <= '0;
    end else begin
      if (take) begin
        kind_q <= KIND_RF;
        idx_q  <= '0;
        trig_q <= sel_trig;
      end else if (state == HOLD && dump_ready_i && !last_word) begin
        if (rf_end) begin
          kind_q <= KIND_DM;
          idx_q  <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
      if (state == CAPTURE) begin
        data_q <= rd_data_i;
      end
    end
  end

`ifdef SNAP_HALT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halt_q <= 1'b0;
    end else if (state == HOLD && dump_ready_i && last_word && all_fired && !any_pending) begin
      halt_q <= 1'b1;
    end
  end
`else
  logic halt_unused;
  assign halt_unused = all_fired;
  assign halt_q      = 1'b0;
`endif

  assign halt_o = halt_q;

endmodule

// File: tb/tb_cycle_snapshot_unit.sv
// Self-checking bench for cycle_snapshot_unit with RF/DM read-port model.
module tb_cycle_snapshot_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] trig = '0;
  logic        rd_en;
  logic        rd_kind;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] data;
  logic        kind;
  logic [3:0]  idx;
  logic        trg;
  logic        last;
  logic [15:0] cyc;
  logic        halt;
  logic        freeze;

`ifdef SNAP_HALT_EN
  localparam logic EXP_HALT = 1'b1;
`else
  localparam logic EXP_HALT = 1'b0;
`endif

  always #5 clk = ~clk;

  cycle_snapshot_unit #(
    .DATA_W   (32),
    .NUM_REGS (16),
    .NUM_MEM  (16),
    .NUM_TRIG (2),
    .CNT_W    (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .trig_cycle_i (trig),
    .freeze_o     (freeze),
    .rd_en_o      (rd_en),
    .rd_kind_o    (rd_kind),
    .rd_idx_o     (rd_idx),
    .rd_data_i    (rd_data),
    .dump_valid_o (valid),
    .dump_ready_i (ready),
    .dump_data_o  (data),
    .dump_kind_o  (kind),
    .dump_idx_o   (idx),
    .dump_trig_o  (trg),
    .dump_last_o  (last),
    .cycle_o      (cyc),
    .halt_o       (halt)
  );

  // RF holds i*3, DM holds 100+i; data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_kind ? (32'd100 + 32'(rd_idx)) : (32'(rd_idx) * 32'd3);
  end

  typedef struct packed {
    logic        last;
    logic        trg;
    logic        kind;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [15:0] cyc;
  } word_t;

  typedef struct {
    int t0;
    int t1;
    int mode;
    int first_slot;
    int first_cyc;
    int second_slot;
    int second_cyc;
    int exp_rises;
  } scen_t;

  word_t q[$];
  word_t cur, prev_word, exp_w;
  bit    prev_hold = 1'b0;
  logic  prev_freeze = 1'b0;
  bit    mon_en = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    rd_cnt = 0;
  int    rises = 0;
  int    ready_mode = 0;
  int    tb_cyc = 0;
  scen_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_dump(input int slot, input int c);
    word_t w;
    for (int i = 0; i < 32; i++) begin
      w.trg  = slot[0];
      w.kind = (i >= 16);
      w.idx  = i[3:0];
      w.data = (i < 16) ? 32'(i * 3) : 32'(100 + i - 16);
      w.last = (i == 31);
      w.cyc  = c[15:0];
      q.push_back(w);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    rd_cnt = 0;
    rises = 0;
    prev_freeze = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    tb_cyc++;
    ready = (ready_mode == 0) || (tb_cyc % 4 == 0);
  end

  // Scoreboard monitor: pops on every accepted word, checks hold stability.
  initial forever begin
    @(negedge clk);
    if (rst || !mon_en) begin
      prev_hold   = 1'b0;
      prev_freeze = 1'b0;
    end else begin
      cur = {last, trg, kind, idx, data, cyc};
      if (prev_hold) check("hold_stable", {valid, cur}, {1'b1, prev_word});
      if (valid && ready) begin
        exp_w = (q.size() > 0) ? q.pop_front() : '1;
        check("dump_word", cur, exp_w);
      end
      prev_hold = valid && !ready;
      prev_word = cur;
      if (rd_en) rd_cnt++;
      if (freeze && !prev_freeze) rises++;
      prev_freeze = freeze;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{12, 15, 0, 0, 12, 1, 15, 2};
    tbl[1] = '{20,  9, 1, 1,  9, 0, 20, 2};
    tbl[2] = '{ 7,  7, 0, 0,  7, 1,  7, 1};
    tbl[3] = '{ 3,  5, 0, 0,  3, 1,  5, 2};

    rst = 1'b1;
    @(negedge clk);
    check("rst_cycle", cyc, 0);
    check("rst_valid", valid, 0);
    check("rst_freeze", freeze, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_halt", halt, 0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      trig = {16'(tbl[i].t1), 16'(tbl[i].t0)};
      ready_mode = tbl[i].mode;
      push_dump(tbl[i].first_slot, tbl[i].first_cyc);
      push_dump(tbl[i].second_slot, tbl[i].second_cyc);
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      run = 1'b1;
      wait_drain($sformatf("scen%0d", i), 3000);
      check($sformatf("scen%0d_halt_at_last", i), halt, 0);
      @(posedge clk);
      #1;
      check($sformatf("scen%0d_halt_after", i), halt, EXP_HALT);
      check($sformatf("scen%0d_freeze_after", i), freeze, EXP_HALT);
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("scen%0d_halt_sticky", i), halt, EXP_HALT);
      check($sformatf("scen%0d_rd_count", i), rd_cnt, 64);
      check($sformatf("scen%0d_freeze_rises", i), rises, tbl[i].exp_rises);
    end

    // Trigger at cycle 0: freeze one cycle after run rises, read the next.
    do_reset();
    trig = {16'd1000, 16'd0};
    ready_mode = 0;
    push_dump(0, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b1;
    check("t0_freeze", freeze, 0);
    check("t0_rd_en", rd_en, 0);
    @(posedge clk);
    #1;
    check("t1_freeze", freeze, 1);
    check("t1_rd_en", rd_en, 0);
    @(posedge clk);
    #1;
    check("t2_rd_en", rd_en, 1);
    check("t2_rd_addr", {rd_kind, rd_idx}, 0);
    wait_drain("trig0", 500);
    @(posedge clk);
    #1;
    check("trig0_freeze_release", freeze, 0);
    repeat (3) @(posedge clk);
    #1;
    check("trig0_count_resumes", cyc, 3);
    check("trig0_halt", halt, 0);
    check("trig0_rd_count", rd_cnt, 32);

    // Asynchronous reset while word 9 is presented, then refire.
    do_reset();
    trig = {16'd1000, 16'd5};
    ready_mode = 0;
    push_dump(0, 5);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b1;
    n = 0;
    while (!(valid && idx == 4'd9) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_word9", {valid, kind, idx}, {1'b1, 1'b0, 4'd9});
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", valid, 0);
    check("arst_freeze", freeze, 0);
    check("arst_cycle", cyc, 0);
    mon_en = 1'b0;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    rd_cnt = 0;
    rises = 0;
    push_dump(0, 5);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b1;
    wait_drain("refire", 500);
    check("refire_rd_count", rd_cnt, 32);
    check("refire_rises", rises, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
